mseq_ctrl: RTL and testbench
============================

# mseq_ctrl

Sequencer for the 4-bit m-sequence generator. It accepts a run command (seed phase, tap type, bit count) and drives the generator one step at a time over a req/ack handshake. Each returned phase is fed back as the next step's phase, and each output bit is packed MSB-first into bytes. The bytes leave on a valid/ready stream that feeds the decoder/display path. It replaces the free-running "count N steps, reload seed" loop with a commanded, backpressure-aware controller.

## Interface
- TIMEOUT, 15: maximum cycles gen_req may wait for gen_ack; range 1..15.
- CLK_50MHZ  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid; equals state==IDLE.
- cmd_fase  in  4  seed phase.
- cmd_type  in  4  tap/type word, held constant for the whole run.
- cmd_len  in  6  number of bits minus one; run length is 1..64 bits.
- gen_req  out  1  step request to the generator.
- gen_fase  out  4  current phase register.
- gen_type  out  4  latched type word.
- gen_ack  in  1  generator step complete; gen_fase_new and gen_bit are valid in this cycle.
- gen_fase_new  in  4  next phase.
- gen_bit  in  1  sequence output bit for this step.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  packed bits; first bit is bit 7; a short final byte is zero-padded in its low bits.
- out_last  out  1  marks the final byte of the run.
- busy  out  1  high whenever state!=IDLE.
- err  out  1  sticky timeout flag; cleared when the next command is accepted.

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch seed, type and len. Clear the bit counter, packer and err. Go to REQ.
  - REQ: assert gen_req and go to WAIT. If issuing this request would complete a byte while the output slot is still full, stay in REQ with gen_req low (stall).
  - WAIT: hold gen_req high with gen_fase and gen_type stable. On gen_ack:
    - phase register <= gen_fase_new;
    - shift gen_bit into the packer;
    - bit counter += 1.
    - Then go to DRAIN if this was the last bit, otherwise to REQ.
  - DRAIN: flush the partial byte with out_last=1. Wait until the final byte handshakes, then go to IDLE.
- When a byte completes (8 bits, or the last bit), load it into the output slot with out_valid=1. The slot holds until out_valid&out_ready.
- A full byte completing exactly on the last bit carries out_last=1; no empty extra byte is emitted.
- Timeout: a 4-bit counter runs in WAIT and is cleared on entry to WAIT. When it reaches TIMEOUT without gen_ack:
  - drop gen_req;
  - set err=1;
  - discard the partial byte and any pending byte (out_valid<=0);
  - go to IDLE.
- gen_ack outside WAIT is ignored.
- cmd_valid outside IDLE is ignored.
- RST at any time returns all registers to their reset values on that edge and abandons any run in progress.
- Reset values:
  - state = IDLE, so cmd_ready = 1 and busy = 0;
  - gen_req = 0, gen_fase = 0, gen_type = 0;
  - out_valid = 0, out_data = 0, out_last = 0;
  - err = 0.

## Timing
- Command accepted at edge N: gen_req=1 from cycle N+1, with gen_fase=cmd_fase.
- gen_ack sampled at edge M: gen_req=0 in cycle M+1, next gen_req=1 in cycle M+2 (one idle cycle minimum). Unstalled throughput is one bit per 3 cycles with a 1-cycle ack.
- A byte completed at the ack edge M has out_valid=1 in cycle M+1.
- Final handshake at edge K: cmd_ready=1 in cycle K+1.
- Timeout: gen_req stays high for exactly TIMEOUT cycles; err=1 and cmd_ready=1 in the following cycle.

## Configuration
- MSEQ_CTRL_LOCKUP_GUARD_EN
  - Defined: a zero phase is substituted with 4'b0001. This applies to cmd_fase at command acceptance and to gen_fase_new at each ack, preventing the all-zero lockup.
  - Undefined: phases pass through unmodified.

## Structure
- mseq_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DRAIN);
  - PHASE_W=4, LEN_W=6, BYTE_W=8;
  - the lockup substitute constant 4'b0001.
- One sub-module, mseq_packer:
  - bit-shift register plus bit index;
  - the single-entry output slot (out_valid/out_data/out_last);
  - a "slot_full" status used for the REQ stall.

## Test plan
Bench generator model: gen_fase_new={fase[2:0], ^(fase&type)}, gen_bit=fase[3], 1-cycle ack, out_ready=1 unless stated.

- Nominal run: seed 0101, type 1101, len 7 -> one byte 0x55 with out_last=1; 8 gen_req pulses; cmd_ready high the cycle after the handshake.
- Partial final byte: same seed and type, len 11 -> 0x55 (out_last=0), then 0x50 (out_last=1).
- Backpressure: len 15, out_ready=0 for 100 cycles -> 15 acks complete, then gen_req stays low. After out_ready=1, 0x55 and then 0x55/last are delivered in order with no loss.
- Timeout: gen_ack tied 0 -> gen_req high for exactly 15 cycles, then err=1, out_valid=0, cmd_ready=1. The next command clears err.
- Reset mid-run: RST asserted during WAIT of bit 5 -> next cycle all outputs at their reset values. A new command runs cleanly.
- Lockup guard: seed 0000, len 7.
  - Macro defined: gen_fase=0001 on the first request.
  - Macro undefined: gen_fase=0000 and out_data=0x00.

Source files
------------

// File: rtl/mseq_pkg.sv
// mseq_pkg: shared types, widths and phase helper for the m-sequence sequencer.
// Contents: state_t (IDLE, REQ, WAIT, DRAIN), PHASE_W/LEN_W/BYTE_W, LOCKUP_FASE,
// guard_fase(). Macro MSEQ_CTRL_LOCKUP_GUARD_EN makes guard_fase replace a zero
// phase with LOCKUP_FASE; without it phases pass through unchanged.
package mseq_pkg;
  localparam int PHASE_W = 4;
  localparam int LEN_W = 6;
  localparam int BYTE_W = 8;
  localparam logic [PHASE_W-1:0] LOCKUP_FASE = 4'b0001;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  function automatic logic [PHASE_W-1:0] guard_fase(input logic [PHASE_W-1:0] f);
`ifdef MSEQ_CTRL_LOCKUP_GUARD_EN
    return (f == '0) ? LOCKUP_FASE : f;
`else
    return f;
`endif
  endfunction
endpackage

// File: rtl/mseq_packer.sv
// mseq_packer: packs bits MSB-first into bytes and holds one output byte.
// Ports: clk, rst (sync, active-high); clr discards partial and pending bytes;
// shift/bit_in/last push one bit (last closes the byte early, zero-padded);
// out_valid/out_ready/out_data/out_last form the output slot; slot_full flags a
// held byte; byte_end means the next bit fills the current byte.
module mseq_packer
  import mseq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              slot_full,
  output logic              byte_end
);
  logic [BYTE_W-1:0] sr, sr_next;
  logic [2:0] idx;
  logic done;
  always_comb begin
    sr_next = sr;
    sr_next[3'd7 - idx] = bit_in;
  end
  assign done = shift & ((idx == 3'd7) | last);
  assign slot_full = out_valid;
  assign byte_end = idx == 3'd7;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (clr) begin
      sr <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (shift) begin
        sr <= done ? '0 : sr_next;
        idx <= done ? 3'd0 : idx + 3'd1;
      end
      if (done) begin
        out_valid <= 1'b1;
        out_data <= sr_next;
        out_last <= last;
      end else if (out_valid & out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mseq_ctrl.sv
// mseq_ctrl: commanded, backpressure-aware sequencer for the 4-bit m-sequence generator.
// Ports: CLK_50MHZ, RST (sync, active-high); cmd_valid/cmd_ready with cmd_fase,
// cmd_type, cmd_len (bits-1); gen_req/gen_ack step handshake with gen_fase,
// gen_type out and gen_fase_new, gen_bit in; out_valid/out_ready/out_data/out_last
// byte stream; busy; err (sticky timeout, cleared on next command).
// Parameter TIMEOUT (1..15): cycles gen_req may wait for gen_ack.
// Macro MSEQ_CTRL_LOCKUP_GUARD_EN: zero phases are replaced by 4'b0001.
module mseq_ctrl
  import mseq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               CLK_50MHZ,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [PHASE_W-1:0] cmd_fase,
  input  logic [PHASE_W-1:0] cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               gen_req,
  output logic [PHASE_W-1:0] gen_fase,
  output logic [PHASE_W-1:0] gen_type,
  input  logic               gen_ack,
  input  logic [PHASE_W-1:0] gen_fase_new,
  input  logic               gen_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err
);
  state_t state, state_nx;
  logic [LEN_W-1:0] len, bcnt;
  logic [3:0] tcnt;
  logic accept, ack, last, stall, tout, slot_full, byte_end;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_ready & cmd_valid;
  assign ack = (state == WAIT) & gen_ack;
  assign last = bcnt == len;
  assign stall = slot_full & (byte_end | last);
  assign tout = (state == WAIT) & ~gen_ack & (tcnt == 4'(TIMEOUT - 1));
  // The slot is always empty at acceptance, so the first request issues
  // straight from IDLE; REQ is only revisited between bits.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = cmd_valid ? WAIT : IDLE;
      REQ:   state_nx = stall ? REQ : WAIT;
      WAIT:  state_nx = gen_ack ? (last ? DRAIN : REQ) : (tout ? IDLE : WAIT);
      DRAIN: state_nx = (out_valid & out_ready) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK_50MHZ) state <= RST ? IDLE : state_nx;
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      gen_req <= 1'b0;
      gen_fase <= '0;
      gen_type <= '0;
      len <= '0;
      bcnt <= '0;
      tcnt <= '0;
      err <= 1'b0;
    end else begin
      gen_req <= state_nx == WAIT;
      tcnt <= (state == WAIT) ? tcnt + 4'd1 : 4'd0;
      if (accept) begin
        gen_fase <= guard_fase(cmd_fase);
        gen_type <= cmd_type;
        len <= cmd_len;
        bcnt <= '0;
        err <= 1'b0;
      end
      if (ack) begin
        gen_fase <= guard_fase(gen_fase_new);
        bcnt <= bcnt + 6'd1;
      end
      if (tout) err <= 1'b1;
    end
  end
  mseq_packer u_packer (
    .clk(CLK_50MHZ),
    .rst(RST),
    .clr(accept | tout),
    .shift(ack),
    .bit_in(gen_bit),
    .last(last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .slot_full(slot_full),
    .byte_end(byte_end)
  );
endmodule

// File: tb/tb_mseq_ctrl.sv
// tb_mseq_ctrl: self-checking bench for mseq_ctrl with a behavioural generator and byte scoreboard.
module tb_mseq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_fase = '0, cmd_type = '0;
  logic [5:0] cmd_len = '0;
  logic gen_req, gen_ack = 1'b0, gen_bit;
  logic [3:0] gen_fase, gen_type, gen_fase_new;
  logic out_valid, out_ready = 1'b1, out_last, busy, err;
  logic [7:0] out_data;
  logic ack_en = 1'b1;
  logic req_q = 1'b0;
  int checks = 0, failures = 0, ack_cnt = 0, req_cnt = 0;
  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  typedef struct {logic [3:0] fase; logic [3:0] typ; logic [5:0] len;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t vecs[6];

  always #5 clk = ~clk;

  mseq_ctrl #(.TIMEOUT(15)) dut (
    .CLK_50MHZ(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fase(cmd_fase),
    .cmd_type(cmd_type), .cmd_len(cmd_len),
    .gen_req(gen_req), .gen_fase(gen_fase), .gen_type(gen_type),
    .gen_ack(gen_ack), .gen_fase_new(gen_fase_new), .gen_bit(gen_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  // generator model: acks one cycle after seeing a request
  always @(posedge clk) gen_ack <= rst ? 1'b0 : (ack_en & gen_req & ~gen_ack);
  assign gen_fase_new = {gen_fase[2:0], ^(gen_fase & gen_type)};
  assign gen_bit = gen_fase[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gf(input logic [3:0] f);
`ifdef MSEQ_CTRL_LOCKUP_GUARD_EN
    return (f == 4'd0) ? 4'b0001 : f;
`else
    return f;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) req_q = 1'b0;
    else begin
      if (gen_ack) ack_cnt++;
      if (gen_req && !req_q) req_cnt++;
      req_q = gen_req;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.l));
        end
      end
    end
  end

  task automatic push_run(input logic [3:0] fase, input logic [3:0] typ, input logic [5:0] len);
    logic [3:0] f;
    logic [7:0] b;
    exp_t x;
    int n;
    f = gf(fase);
    b = '0;
    n = int'(len);
    for (int i = 0; i <= n; i++) begin
      b[7 - (i % 8)] = f[3];
      f = gf({f[2:0], ^(f & typ)});
      if (i % 8 == 7 || i == n) begin
        x.d = b;
        x.l = (i == n);
        q.push_back(x);
        b = '0;
      end
    end
  endtask

  task automatic send_cmd(input logic [3:0] fase, input logic [3:0] typ, input logic [5:0] len, input bit push);
    cmd_fase = fase;
    cmd_type = typ;
    cmd_len = len;
    cmd_valid = 1'b1;
    if (push) push_run(fase, typ, len);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("first_req", 32'(gen_req), 1);
    check("first_fase", 32'(gen_fase), 32'(gf(fase)));
    check("type_latch", 32'(gen_type), 32'(typ));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check({name, "_done"}, 32'(cmd_ready), 1);
    check({name, "_drained"}, 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_gen_req"}, 32'(gen_req), 0);
    check({name, "_gen_fase"}, 32'(gen_fase), 0);
    check({name, "_gen_type"}, 32'(gen_type), 0);
    check({name, "_out_valid"}, 32'(out_valid), 0);
    check({name, "_out_data"}, 32'(out_data), 0);
    check({name, "_out_last"}, 32'(out_last), 0);
    check({name, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, hi;
    vecs[0] = '{4'h5, 4'hD, 6'd7};
    vecs[1] = '{4'h5, 4'hD, 6'd11};
    vecs[2] = '{4'h9, 4'h3, 6'd0};
    vecs[3] = '{4'hC, 4'h9, 6'd8};
    vecs[4] = '{4'h7, 4'hC, 6'd63};
    vecs[5] = '{4'h3, 4'h6, 6'd15};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      base = req_cnt;
      send_cmd(vecs[i].fase, vecs[i].typ, vecs[i].len, 1);
      wait_idle("vec", 400);
      check("vec_req_pulses", 32'(req_cnt - base), 32'(int'(vecs[i].len) + 1));
      check("vec_err", 32'(err), 0);
    end
    // nominal run with cycle-level timing
    base = req_cnt;
    send_cmd(4'h5, 4'hD, 6'd7, 1);
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (gen_ack) begin
        n++;
        if (n == 1) begin
          @(negedge clk);
          check("req_gap", 32'(gen_req), 0);
          @(negedge clk);
          check("req_again", 32'(gen_req), 1);
        end
      end
    end
    check("nom_acks", 32'(n), 8);
    @(negedge clk);
    check("nom_valid", 32'(out_valid), 1);
    check("nom_byte", 32'(out_data), 32'h55);
    check("nom_last", 32'(out_last), 1);
    check("nom_busy", 32'(cmd_ready), 0);
    @(negedge clk);
    check("nom_ready_after", 32'(cmd_ready), 1);
    check("nom_req_pulses", 32'(req_cnt - base), 8);
    @(posedge clk);
    #1;
    // backpressure
    out_ready = 1'b0;
    base = ack_cnt;
    send_cmd(4'h5, 4'hD, 6'd15, 1);
    repeat (100) @(negedge clk);
    check("bp_acks", 32'(ack_cnt - base), 15);
    check("bp_req_low", 32'(gen_req), 0);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_busy", 32'(busy), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("bp", 200);
    // timeout
    ack_en = 1'b0;
    send_cmd(4'h5, 4'hD, 6'd7, 0);
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!gen_req) break;
      hi++;
    end
    check("to_req_cycles", 32'(hi), 15);
    check("to_err", 32'(err), 1);
    check("to_valid", 32'(out_valid), 0);
    check("to_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 ack_en = 1'b1;
    send_cmd(4'h3, 4'h6, 6'd9, 1);
    check("to_err_clear", 32'(err), 0);
    wait_idle("to_next", 200);
    // reset during WAIT of bit 5
    base = ack_cnt;
    send_cmd(4'h5, 4'hD, 6'd15, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ack_cnt - base >= 4 && gen_req && !gen_ack) break;
    end
    check("mid_in_wait", 32'(gen_req), 1);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    @(posedge clk);
    #1;
    send_cmd(4'h5, 4'hD, 6'd11, 1);
    wait_idle("post_reset", 200);
    // zero seed
    send_cmd(4'h0, 4'hD, 6'd7, 1);
    wait_idle("lockup", 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
